// File: rtl/gf_op_sequencer.sv
// Sequencer for a shared add/mult/exp/reduce datapath: accepts one request at a time,
// runs EXEC (and RED for valid GF ops), then holds the result until the consumer takes it.
module gf_op_sequencer #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                in_op,
    input  logic                      in_carry,
    input  logic [DATA_WIDTH-1:0]     in_a,
    input  logic [DATA_WIDTH-1:0]     in_b,
    input  logic                      cfg_we,
    input  logic [DATA_WIDTH:0]       cfg_poly,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*DATA_WIDTH-1:0]   out_res,
    output logic                      out_err,
    output logic                      dp_sum_funct,
    output logic                      dp_exp_funct,
    output logic                      dp_red_funct,
    output logic                      dp_carry_option,
    output logic [DATA_WIDTH-1:0]     dp_a,
    output logic [DATA_WIDTH-1:0]     dp_b,
    output logic [DATA_WIDTH:0]       dp_polyn_red_in,
    output logic [2*DATA_WIDTH-1:0]   dp_reduc_in,
    input  logic [DATA_WIDTH-1:0]     dp_out,
    input  logic [2*DATA_WIDTH-1:0]   dp_mult_out
);

    localparam int unsigned N     = DATA_WIDTH;
    localparam int unsigned RES_W = 2 * DATA_WIDTH;

    localparam logic [1:0] OP_ADD    = 2'b00;
    localparam logic [1:0] OP_MUL    = 2'b01;
    localparam logic [1:0] OP_GF_SQR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RED  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic               carry_q, carry_d;
    logic [N-1:0]       a_q, a_d;
    logic [N-1:0]       b_q, b_d;
    logic [N:0]         poly_q, poly_d;
    logic [N:0]         lpoly_q, lpoly_d;
    logic [RES_W-1:0]   prod_q, prod_d;
    logic [RES_W-1:0]   res_q, res_d;
    logic               err_q, err_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               sum_q, sum_d;
    logic               exp_q, exp_d;
    logic               red_q, red_d;
    logic               copt_q, copt_d;
    logic [N-1:0]       dp_b_q, dp_b_d;

    // Next-state, datapath capture and next values of the registered outputs
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        lpoly_d     = lpoly_q;
        prod_d      = prod_q;
        res_d       = res_q;
        err_d       = err_q;
        poly_d      = cfg_we ? cfg_poly : poly_q;
        sum_d       = 1'b0;
        exp_d       = 1'b0;
        red_d       = 1'b0;
        copt_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d    = in_op;
                    carry_d = in_carry;
                    a_d     = in_a;
                    b_d     = in_b;
                    lpoly_d = poly_q;
                    err_d   = 1'b0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (op_q == OP_ADD) begin
                    res_d   = RES_W'(dp_out);
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (op_q == OP_MUL) begin
                    res_d   = dp_mult_out;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    prod_d = dp_mult_out;
                    // Without the leading term there is no field to reduce into
                    if (lpoly_q[N]) begin
                        state_d = S_RED;
                    end else begin
                        res_d   = dp_mult_out;
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_RED: begin
                res_d   = RES_W'(dp_out);
                err_d   = 1'b0;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        dp_b_d      = b_d;
        if (state_d == S_EXEC) begin
            sum_d  = (op_d == OP_ADD);
            exp_d  = (op_d == OP_GF_SQR);
            copt_d = carry_d & ~op_d[1];
            if (op_d == OP_GF_SQR) begin
                dp_b_d = a_d;
            end
        end
        if (state_d == S_RED) begin
            red_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            poly_q      <= '0;
            lpoly_q     <= '0;
            prod_q      <= '0;
            res_q       <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            sum_q       <= 1'b0;
            exp_q       <= 1'b0;
            red_q       <= 1'b0;
            copt_q      <= 1'b0;
            dp_b_q      <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            poly_q      <= poly_d;
            lpoly_q     <= lpoly_d;
            prod_q      <= prod_d;
            res_q       <= res_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            exp_q       <= exp_d;
            red_q       <= red_d;
            copt_q      <= copt_d;
            dp_b_q      <= dp_b_d;
        end
    end

    assign in_ready        = in_ready_q;
    assign out_valid       = out_valid_q;
    assign out_res         = res_q;
    assign out_err         = err_q;
    assign dp_sum_funct    = sum_q;
    assign dp_exp_funct    = exp_q;
    assign dp_red_funct    = red_q;
    assign dp_carry_option = copt_q;
    assign dp_a            = a_q;
    assign dp_b            = dp_b_q;
    assign dp_polyn_red_in = lpoly_q;
    assign dp_reduc_in     = prod_q;

endmodule

// File: tb/tb_gf_op_sequencer.sv
// Bench for gf_op_sequencer at DATA_WIDTH=8: behavioural datapath, polynomial-arithmetic
// reference model, directed corner cases plus randomized requests.
module tb_gf_op_sequencer;

    localparam int unsigned N = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic             in_carry;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic             cfg_we;
    logic [N:0]       cfg_poly;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   out_res;
    logic             out_err;
    logic             dp_sum_funct;
    logic             dp_exp_funct;
    logic             dp_red_funct;
    logic             dp_carry_option;
    logic [N-1:0]     dp_a;
    logic [N-1:0]     dp_b;
    logic [N:0]       dp_polyn_red_in;
    logic [2*N-1:0]   dp_reduc_in;
    logic [N-1:0]     dp_out;
    logic [2*N-1:0]   dp_mult_out;

    int               n_checks;
    int               n_errors;
    logic [N:0]       ref_poly;

    gf_op_sequencer #(.DATA_WIDTH(N)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_op           (in_op),
        .in_carry        (in_carry),
        .in_a            (in_a),
        .in_b            (in_b),
        .cfg_we          (cfg_we),
        .cfg_poly        (cfg_poly),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_res         (out_res),
        .out_err         (out_err),
        .dp_sum_funct    (dp_sum_funct),
        .dp_exp_funct    (dp_exp_funct),
        .dp_red_funct    (dp_red_funct),
        .dp_carry_option (dp_carry_option),
        .dp_a            (dp_a),
        .dp_b            (dp_b),
        .dp_polyn_red_in (dp_polyn_red_in),
        .dp_reduc_in     (dp_reduc_in),
        .dp_out          (dp_out),
        .dp_mult_out     (dp_mult_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] clmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ (16'(a) << i);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_reduce(input logic [15:0] p, input logic [8:0] poly);
        logic [15:0] r;
        r = p;
        for (int i = 15; i >= 8; i--) begin
            if (r[i]) r = r ^ (16'(poly) << (i - 8));
        end
        return r[7:0];
    endfunction

    // Behavioural shared datapath driven by the sequencer
    always_comb begin
        logic [7:0] s;
        s           = dp_a + dp_b;
        dp_mult_out = dp_carry_option ? (16'(dp_a) * 16'(dp_b)) : clmul(dp_a, dp_b);
        if (dp_red_funct)      dp_out = gf_reduce(dp_reduc_in, dp_polyn_red_in);
        else if (dp_sum_funct) dp_out = dp_carry_option ? s : (dp_a ^ dp_b);
        else                   dp_out = dp_mult_out[7:0];
    end

    function automatic void ref_model(input logic [1:0] op, input logic c, input logic [7:0] a,
                                      input logic [7:0] b, input logic [8:0] poly,
                                      output logic [15:0] r, output logic e);
        logic [7:0]  s;
        logic [15:0] p;
        s = a + b;
        e = 1'b0;
        case (op)
            2'b00:   r = c ? {8'h00, s} : {8'h00, a ^ b};
            2'b01:   r = c ? (16'(a) * 16'(b)) : clmul(a, b);
            default: begin
                p = clmul(a, (op == 2'b11) ? a : b);
                if (poly[8]) r = {8'h00, gf_reduce(p, poly)};
                else begin
                    r = p;
                    e = 1'b1;
                end
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_err"}, 32'(out_err), 32'd0);
        check({tag, "_out_res"}, 32'(out_res), 32'd0);
        check({tag, "_dp_ctrl"},
              32'({dp_sum_funct, dp_exp_funct, dp_red_funct, dp_carry_option}), 32'd0);
        check({tag, "_dp_data"}, {dp_a, dp_b, 16'h0000}, 32'd0);
        check({tag, "_dp_red_data"}, 32'({dp_polyn_red_in, dp_reduc_in}), 32'd0);
    endtask

    task automatic cfg_write(input logic [8:0] p);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_poly = p;
        ref_poly = p;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    // One request: optional cfg write in the accept cycle or during EXEC, optional hold of out_ready
    task automatic do_op(input string tag, input logic [1:0] op, input logic c,
                         input logic [7:0] a, input logic [7:0] b,
                         input bit acc_cfg, input bit mid_cfg, input logic [8:0] np,
                         input int hold);
        logic [15:0] er;
        logic        ee;
        int          lat;
        int          exp_lat;
        ref_model(op, c, a, b, ref_poly, er, ee);
        exp_lat = (op[1] && !ee) ? 3 : 2;
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_carry = c;
        in_a     = a;
        in_b     = b;
        if (acc_cfg) begin
            cfg_we   = 1'b1;
            cfg_poly = np;
            ref_poly = np;
        end
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            cfg_we   = 1'b0;
            lat++;
            if (lat == 1) begin
                check({tag, "_exec_ctrl"},
                      32'({dp_sum_funct, dp_exp_funct, dp_red_funct, dp_carry_option}),
                      32'({op == 2'b00, op == 2'b11, 1'b0, c & ~op[1]}));
                if (mid_cfg) begin
                    cfg_we   = 1'b1;
                    cfg_poly = np;
                    ref_poly = np;
                end
            end
        end while (!out_valid && lat < 20);
        cfg_we = 1'b0;
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, 32'(out_res), 32'(er));
        check({tag, "_err"}, 32'(out_err), 32'(ee));
        check({tag, "_done_ctrl"},
              32'({dp_sum_funct, dp_exp_funct, dp_red_funct, dp_carry_option}), 32'd0);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_op    = 2'($urandom);
            in_a     = 8'($urandom);
            @(negedge clk);
            check({tag, "_hold_res"}, 32'(out_res), 32'(er));
            check({tag, "_hold_state"}, 32'({out_valid, in_ready}), 32'b10);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_post_hs"}, 32'({out_valid, in_ready}), 32'b01);
    endtask

    initial begin
        logic [1:0] rop;
        logic [8:0] rnp;
        bit         seen_valid;
        n_checks  = 0;
        n_errors  = 0;
        ref_poly  = '0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_carry  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        cfg_we    = 1'b0;
        cfg_poly  = '0;
        out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;

        // No prior poly write; a write in the accept cycle must not rescue this request
        do_op("nocfg", 2'b10, 1'b0, 8'h53, 8'hCA, 1'b1, 1'b0, 9'h11B, 0);
        do_op("gfmul", 2'b10, 1'b0, 8'h53, 8'hCA, 1'b0, 1'b0, 9'h000, 0);
        check("gfmul_inverse", 32'(out_res), 32'h0001);
        do_op("gfsqr02", 2'b11, 1'b0, 8'h02, 8'h77, 1'b0, 1'b0, 9'h000, 0);
        check("gfsqr02_val", 32'(out_res), 32'h0004);
        do_op("gfsqr80", 2'b11, 1'b0, 8'h80, 8'h00, 1'b0, 1'b0, 9'h000, 0);
        do_op("mul_int", 2'b01, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 9'h000, 0);
        check("mul_int_val", 32'(out_res), 32'hFE01);
        do_op("mul_clm", 2'b01, 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0, 9'h000, 0);
        do_op("add_int", 2'b00, 1'b1, 8'h0F, 8'h01, 1'b0, 1'b0, 9'h000, 0);
        check("add_int_val", 32'(out_res), 32'h0010);
        do_op("add_xor", 2'b00, 1'b0, 8'h0F, 8'h01, 1'b0, 1'b0, 9'h000, 0);
        check("add_xor_val", 32'(out_res), 32'h000E);
        do_op("backpr", 2'b10, 1'b0, 8'h57, 8'h83, 1'b0, 1'b0, 9'h000, 5);
        do_op("midcfg", 2'b10, 1'b0, 8'hA5, 8'h3C, 1'b0, 1'b1, 9'h0F5, 0);
        do_op("aftercfg", 2'b10, 1'b0, 8'hA5, 8'h3C, 1'b0, 1'b0, 9'h000, 0);
        cfg_write(9'h11B);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom);
            rnp = {1'($urandom_range(0, 3) != 0), 8'($urandom)};
            do_op("rand", rop, 1'($urandom), 8'($urandom), 8'($urandom),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), rnp,
                  int'($urandom_range(0, 2)));
        end

        // Reset pulsed while the request sits in RED
        cfg_write(9'h11B);
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 2'b10;
        in_a     = 8'h53;
        in_b     = 8'hCA;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("red_entered", 32'(dp_red_funct), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        check_reset_outputs("midrst_hold");
        rst_n    = 1'b1;
        ref_poly = '0;
        seen_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        check("midrst_no_result", 32'(seen_valid), 32'd0);
        do_op("postrst_nocfg", 2'b10, 1'b0, 8'h53, 8'hCA, 1'b0, 1'b0, 9'h000, 0);
        cfg_write(9'h11B);
        do_op("postrst_gf", 2'b10, 1'b0, 8'h53, 8'hCA, 1'b0, 1'b0, 9'h000, 0);
        check("postrst_gf_val", 32'(out_res), 32'h0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
